// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - shared constants and state encoding for the text-RAM write queue
package ascii_pkg;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] CLEAR_DATA = 32'h20FF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;
endpackage

// File: rtl/ascii_fifo.sv
// rtl/ascii_fifo.sv - write-entry FIFO with head lookahead for registered draining
module ascii_fifo
    import ascii_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = ADDR_W + DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             head,
    output logic [W-1:0]             head_next,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;

    // Pointer and occupancy update; flush wins over any push/pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == (PW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Entry storage; contents are don't-care until written so it carries no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    // head_next is what the head becomes after a pop; with one entry left it is the
    // entry being pushed in the same cycle (not yet in storage).
    assign head      = mem_q[rd_ptr_q];
    assign head_next = (count_q > (PW+1)'(1)) ? mem_q[rd_ptr_q + PW'(1)] : wr_data;
    assign level     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
endmodule

// File: rtl/ascii_write_queue.sv
// rtl/ascii_write_queue.sv - deduplicating text-RAM write queue with screen-clear sequencer
module ascii_write_queue
    import ascii_pkg::*;
#(
    parameter int                DEPTH      = 8,
    parameter int                CELLS      = COLS * ROWS,
    parameter logic [DATA_W-1:0] CLEAR_DATA = ascii_pkg::CLEAR_DATA
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_en,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   clear_req,
    input  logic                   out_ready,
    output logic                   out_we,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [DATA_W-1:0]      out_data,
    output logic                   busy,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int PAIR_W = ADDR_W + DATA_W;

    state_t              state_q, state_d;
    logic                prev_en_q, prev_en_d;
    logic [PAIR_W-1:0]   last_pair_q, last_pair_d;
    logic [ADDR_W-1:0]   counter_q, counter_d;
    logic                out_we_q, out_we_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                overflow_q, overflow_d;
    logic                busy_q, busy_d;

    logic [PAIR_W-1:0]   pair, f_head, f_next;
    logic [LW-1:0]       f_level;
    logic                f_full, f_empty;
    logic                push_req, push_acc, pop, xfer;

    // A held strobe only re-pushes when the address/data pair changes.
    assign pair     = {in_addr, in_data};
    assign xfer     = out_we_q & out_ready;
    assign push_req = in_en & (~prev_en_q | (pair != last_pair_q));
    assign pop      = (state_q == ST_DRAIN) & xfer & ~clear_req;
    assign push_acc = push_req & ~clear_req & (~f_full | pop);

    ascii_fifo #(.DEPTH(DEPTH), .W(PAIR_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_acc),
        .pop       (pop),
        .flush     (clear_req),
        .wr_data   (pair),
        .head      (f_head),
        .head_next (f_next),
        .level     (f_level),
        .full      (f_full),
        .empty     (f_empty)
    );

    // Next-state and registered-output computation for IDLE/DRAIN/CLEAR.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        out_we_d    = out_we_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        prev_en_d   = in_en;
        last_pair_d = push_req ? pair : last_pair_q;
        overflow_d  = overflow_q | (push_req & ~clear_req & f_full & ~pop);
        if (clear_req) begin
            state_d   = ST_CLEAR;
            counter_d = '0;
            out_we_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_we_d = 1'b0;
                    if (f_level != '0) begin
                        state_d                  = ST_DRAIN;
                        out_we_d                 = 1'b1;
                        {out_addr_d, out_data_d} = f_head;
                    end
                end
                ST_DRAIN: begin
                    if (xfer) begin
                        if (f_level == LW'(1) && !push_acc) begin
                            state_d  = ST_IDLE;
                            out_we_d = 1'b0;
                        end else begin
                            out_we_d                 = 1'b1;
                            {out_addr_d, out_data_d} = f_next;
                        end
                    end
                end
                ST_CLEAR: begin
                    out_we_d   = 1'b1;
                    out_addr_d = counter_q;
                    out_data_d = CLEAR_DATA;
                    if (xfer) begin
                        if (counter_q == ADDR_W'(CELLS - 1)) begin
                            if (f_level != '0) begin
                                state_d                  = ST_DRAIN;
                                {out_addr_d, out_data_d} = f_head;
                            end else begin
                                state_d  = ST_IDLE;
                                out_we_d = 1'b0;
                            end
                        end else begin
                            counter_d  = counter_q + ADDR_W'(1);
                            out_addr_d = counter_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    out_we_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state, edge-detect history and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            counter_q   <= '0;
            out_we_q    <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            prev_en_q   <= 1'b0;
            last_pair_q <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            out_we_q    <= out_we_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            prev_en_q   <= prev_en_d;
            last_pair_q <= last_pair_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
        end
    end

    assign out_we   = out_we_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign full     = f_full;
    assign empty    = f_empty;
    assign level    = f_level;
endmodule

// File: tb/tb_ascii_write_queue.sv
// tb/tb_ascii_write_queue.sv - randomized and directed bench with a queue-level reference model
module tb_ascii_write_queue;
    localparam int          DEPTH = 8;
    localparam int          CELLS = 2400;
    localparam logic [31:0] CLR   = 32'h20FF_FFFF;
    localparam logic [31:0] DA    = 32'h41FF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_en = 1'b0;
    logic [12:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic        clear_req = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_we, busy, full, empty, overflow;
    logic [12:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  level;

    always #5 clk = ~clk;

    ascii_write_queue #(.DEPTH(DEPTH), .CELLS(CELLS), .CLEAR_DATA(CLR)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_addr(in_addr), .in_data(in_data),
        .clear_req(clear_req), .out_ready(out_ready), .out_we(out_we), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .full(full), .empty(empty), .overflow(overflow),
        .level(level)
    );

    logic [44:0] mq[$];
    logic [44:0] wlog[$];
    bit          m_prev_en, m_clearing, m_clr_first, m_ovf, stall_prev;
    logic [44:0] m_last, stall_pair;
    int          m_cnt, m_prev_size;
    int          n_vec = 0, n_err = 0, cyc = 0, first_we = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [44:0] wl(input int i);
        return (i < wlog.size()) ? wlog[i] : '1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_prev_en = 0; m_last = '0; m_clearing = 0; m_clr_first = 0;
        m_ovf = 0; m_cnt = 0; m_prev_size = 0; stall_prev = 0;
    endtask

    task automatic cycle(input bit en, input logic [12:0] a, input logic [31:0] d,
                         input bit clr, input bit rdy);
        logic [44:0] pr;
        bit xfer, preq, pop, busy_e;
        in_en = en; in_addr = a; in_data = d; clear_req = clr; out_ready = rdy;
        pr = {a, d};
        if (out_we && first_we < 0) first_we = cyc;
        if (stall_prev && out_we) chk("hold_stable", {out_addr, out_data}, stall_pair);
        stall_prev = out_we && !rdy && !clr;
        stall_pair = {out_addr, out_data};
        xfer = out_we && rdy;
        if (xfer) begin
            if (m_clearing)        chk("ram_write_clear", {out_addr, out_data}, {13'(m_cnt), CLR});
            else if (mq.size() > 0) chk("ram_write_entry", {out_addr, out_data}, mq[0]);
            else                    chk("ghost_write", 1, 0);
            wlog.push_back({out_addr, out_data});
        end
        preq = en && (!m_prev_en || pr != m_last);
        m_prev_en = en;
        if (preq) m_last = pr;
        m_prev_size = mq.size();
        if (clr) begin
            mq.delete();
            m_clearing = 1; m_cnt = 0; m_clr_first = 1;
        end else begin
            m_clr_first = 0;
            pop = xfer && !m_clearing;
            if (xfer && m_clearing) begin
                m_cnt++;
                if (m_cnt == CELLS) m_clearing = 0;
            end
            if (preq) begin
                if (mq.size() < DEPTH || pop) mq.push_back(pr);
                else m_ovf = 1;
            end
            if (pop && mq.size() > 0) void'(mq.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        busy_e = m_clearing || (mq.size() > 0 && m_prev_size > 0);
        chk("level", level, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, busy_e);
        chk("out_we", out_we, busy_e && !m_clr_first);
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) cycle(0, '0, '0, 0, rdy);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_out_we", out_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0);
        model_reset();
        in_en = 0; clear_req = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            cycle(0, '0, '0, 0, 1);
            k++;
        end
        chk(name, k < budget, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p;
        model_reset();
        @(negedge clk);
        do_reset();

        // Held strobe with a constant pair produces exactly one write.
        wlog.delete();
        repeat (10) cycle(1, 13'd5, DA, 0, 1);
        idle(6, 1);
        chk("hold_one_write", wlog.size(), 1);
        chk("hold_write_pair", wl(0), {13'd5, DA});

        // Stepping address: ordered writes and two-cycle latency.
        do_reset();
        wlog.delete();
        first_we = -1;
        p = cyc;
        for (int i = 0; i < 3; i++) cycle(1, 13'(i), DA, 0, 1);
        idle(6, 1);
        chk("step_count", wlog.size(), 3);
        chk("step_w0", wl(0), {13'd0, DA});
        chk("step_w1", wl(1), {13'd1, DA});
        chk("step_w2", wl(2), {13'd2, DA});
        chk("first_we_latency", first_we - p, 2);

        // Overflow: nine pushes with the RAM stalled.
        do_reset();
        wlog.delete();
        for (int i = 0; i < 9; i++) cycle(1, 13'(10 + i), DA, 0, 0);
        idle(1, 0);
        chk("ovf_full", full, 1);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_level", level, 8);
        idle(12, 1);
        chk("ovf_write_count", wlog.size(), 8);
        chk("ovf_first", wl(0), {13'd10, DA});
        chk("ovf_last", wl(7), {13'd17, DA});

        // Clear flushes queued entries and sweeps every cell.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 13'(20 + i), DA, 0, 0);
        idle(1, 0);
        cycle(0, '0, '0, 1, 0);
        chk("clr_flush_level", level, 0);
        wlog.delete();
        run_until_idle("clr_in_budget", 3000);
        chk("clr_count", wlog.size(), CELLS);
        chk("clr_first", wl(0), {13'd0, CLR});
        chk("clr_last", wl(CELLS - 1), {13'(CELLS - 1), CLR});
        chk("clr_busy_after", busy, 0);

        // Push during clear lands after the final clear write.
        cycle(0, '0, '0, 1, 1);
        wlog.delete();
        idle(100, 1);
        cycle(1, 13'd7, DA, 0, 1);
        run_until_idle("clr_push_in_budget", 3000);
        chk("clr_push_count", wlog.size(), CELLS + 1);
        chk("clr_push_prev", wl(CELLS - 1), {13'(CELLS - 1), CLR});
        chk("clr_push_cell7", wl(CELLS), {13'd7, DA});

        // Reset in the middle of a clear with a toggling ready.
        cycle(0, '0, '0, 1, 1);
        for (int i = 0; i < 500; i++) cycle(0, '0, '0, 0, 1'(i % 2));
        do_reset();
        wlog.delete();
        for (int i = 0; i < 20; i++) cycle(0, '0, '0, 0, 1'(i % 2));
        chk("post_rst_no_writes", wlog.size(), 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  13'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? DA : 32'h4200_0001,
                  $urandom_range(0, 1499) == 0,
                  $urandom_range(0, 9) < 7);
        end
        idle(3000, 1);
        chk("rand_settled", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ascii_write_queue.md
ASCII_WRITE_QUEUE -- requirements
Module: ascii_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries, power of two.
REQ-002 SHALL have parameter CELLS, default 2400: text cells cleared (80 x 30).
REQ-003 SHALL have parameter CLEAR_DATA, default 32'h20FF_FFFF: space character plus white attribute.
REQ-004 SHALL have port clk  in  1: clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_en  in  1: core write strobe; may stay high for many cycles.
REQ-007 SHALL have port in_addr  in  13: target cell address.
REQ-008 SHALL have port in_data  in  32: [31:24] ASCII, [23:0] colour.
REQ-009 SHALL have port clear_req  in  1: single-cycle screen-clear request.
REQ-010 SHALL have port out_ready  in  1: text RAM accepts a write this cycle.
REQ-011 SHALL have ports out_we  out  1, out_addr  out  13, out_data  out  32: write to the text RAM.
REQ-012 SHALL have ports busy  out  1, full  out  1, empty  out  1, overflow  out  1, level  out  $clog2(DEPTH)+1.

Function
REQ-013 SHALL push when in_en=1 and either in_en was 0 last cycle or {in_addr,in_data} differs from the last pushed pair.
REQ-014 SHALL accept a push when not full, or when full with a pop in the same cycle.
REQ-015 SHALL drop a push while full with no pop, and SHALL set overflow sticky.
REQ-016 SHALL transfer on out_we & out_ready, with at most one transfer per cycle.
REQ-017 SHALL hold out_addr and out_data stable while out_we=1 and out_ready=0.
REQ-018 SHALL have all outputs registered; after a push into an empty queue, out_we rises exactly 2 cycles later.
REQ-019 SHALL implement FSM IDLE -> DRAIN when queue non-empty; DRAIN -> IDLE when the last entry transfers.
REQ-020 SHALL, in DRAIN, present the FIFO head and pop it on transfer; back-to-back transfers SHALL occur with out_ready held high.
REQ-021 SHALL, on clear_req in any state: flush the FIFO in that cycle (including an unaccepted out_we entry); drop a push in that same cycle; deassert out_we; enter CLEAR next cycle with the cell counter at 0.
REQ-022 SHALL, in CLEAR, issue out_addr=counter and out_data=CLEAR_DATA, advancing the counter on each transfer.
REQ-023 SHALL, in CLEAR, go to DRAIN after the transfer at counter CELLS-1 if the queue is non-empty, else to IDLE.
REQ-024 SHALL accept pushes during CLEAR and drain them after CLEAR, in arrival order.
REQ-025 SHALL restart the counter at 0 on clear_req during CLEAR.
REQ-026 SHALL drive busy = (state != IDLE); full = (level == DEPTH); empty = (level == 0).
REQ-027 SHALL wrap FIFO pointers modulo DEPTH; level SHALL never exceed DEPTH.

Reset
REQ-028 SHALL on rst=0 immediately force state IDLE, level 0, empty 1, full 0, overflow 0, busy 0, out_we 0, out_addr 0, out_data 0, counter 0, and clear the edge-detect history.
REQ-029 SHALL discard any in-progress DRAIN or CLEAR on reset, with no partial write after release.

Structure
REQ-030 SHALL take COLS=80, ROWS=30, ADDR_W=13, CLEAR_DATA and the state encoding from shared package ascii_pkg.
REQ-031 SHALL place FIFO storage and pointers in one sub-module, ascii_fifo; the FSM, edge detection and clear counter SHALL stay in ascii_write_queue.

Verification
REQ-032 SHALL cover: in_en held high 10 cycles, addr=5, data=32'h41FFFFFF -> exactly one RAM write to cell 5.
REQ-033 SHALL cover: in_en held high with addr stepping 0,1,2 and out_ready=1 -> writes 0,1,2 in order; out_we first high 2 cycles after first push.
REQ-034 SHALL cover: out_ready=0, 9 distinct pushes -> full=1 after 8, overflow=1; then out_ready=1 -> exactly 8 writes, the 9th absent.
REQ-035 SHALL cover: 3 entries queued, then clear_req -> queue flushed; 2400 writes of 32'h20FFFFFF to addresses 0..2399; busy=0 after.
REQ-036 SHALL cover: push addr=7 during CLEAR -> the cell-7 write follows the address-2399 clear write.
REQ-037 SHALL cover: rst=0 mid-CLEAR with out_ready toggling -> out_we=0 immediately, no writes after release until a new push.
